paddle_pot_timer: RTL and testbench
===================================

// Module: paddle_pot_timer
// PURPOSE
//  Emulates the TIA pot-port charge timing for four analog paddle channels.
//  Sits between the per-player paddle controllers, which produce 8-bit
//  positions, and the console core's INPT0..INPT3 D7 read bits.
//  While the dump line is held, the pot capacitors are discharged. On release,
//  each channel counts scanlines and reports "charged" once its
//  position-derived threshold is reached.
// PARAMETERS
//  MIN_LINES  8  scanlines added to every threshold (paddle 0 never reads charged at line 0)
//  STEP       1  scanlines per paddle LSB; MIN_LINES + 255*STEP must be < 511
//  CNT_W      9  line counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1   core clock (same domain as the console core)
//  reset_n    in   1   asynchronous, active-low reset
//  ce         in   1   clock enable; all state advances only when ce=1
//  dump       in   1   1 = pots grounded (VBLANK D7)
//  hsync      in   1   raw horizontal sync; the rising edge marks one scanline
//  paddle     in   32  {p4,p3,p2,p1} 8-bit positions (0 = fastest charge)
//  pot_in     out  4   per-channel INPT D7: 1 = charged
//  busy       out  1   1 while in CHARGE state
// BEHAVIOUR
//  Reset: pot_in=0, busy=0, state=DUMP, line counter=0, latched thresholds=0, hsync edge reg=0.
//  All updates below happen on clk edges with ce=1; with ce=0 every register holds.
//  Edge detect: hs_q <= hsync; line_tick = hsync & ~hs_q (one ce-cycle pulse).
//  State machine (states DUMP, CHARGE, DONE):
//   DUMP:   cnt<=0, pot_in<=0, busy<=0.
//           If dump=0: latch thr[i] = MIN_LINES + paddle[i]*STEP (CNT_W bits) for all
//           four channels in the same cycle; go to CHARGE.
//   CHARGE: busy=1. On line_tick: cnt<=cnt+1.
//           pot_in[i] <= (cnt >= thr[i]), evaluated every ce-cycle against the registered cnt,
//           so pot_in rises one ce-cycle after cnt reaches thr[i].
//           When all four pot_in bits are 1, or cnt = 2^CNT_W-1: go to DONE.
//   DONE:   pot_in<=4'b1111, busy<=0, cnt holds.
//  dump=1 in any state: next ce-cycle state=DUMP, pot_in=0, cnt=0. This has priority over line_tick.
//  Counter saturates; it never wraps to 0 while dump=0.
//  paddle changes during CHARGE or DONE are ignored until the next dump release.
//  dump release coincident with line_tick: the threshold latch occurs; the tick is NOT counted.
//  Threshold arithmetic is unsigned; thr values are held in CNT_W-bit registers.
//  Latency: dump release -> first possible pot_in=1 is MIN_LINES line_ticks plus 1 ce-cycle.
// CONFIGURATION
//  PADDLE_SMOOTH_EN defined: each channel keeps its previous latched position prev[i]
//   (reset 0). At dump release it latches pos = (prev[i] + paddle[i] + 1) >> 1 using a
//   9-bit sum, sets prev[i] <= pos, and computes thr from pos. This halves jitter
//   from mouse and analog-stick sources.
//  PADDLE_SMOOTH_EN undefined: pos = paddle[i] directly; no prev registers exist.
// TESTING
//  1 reset_n=0 mid-CHARGE -> pot_in=0, busy=0 immediately (async); after release, state=DUMP.
//  2 paddle=all 0, release dump, 8 line_ticks -> pot_in=4'b1111 one ce after 8th tick; busy then 0.
//  3 paddle={8'd255,8'd100,8'd10,8'd0}, STEP=1 -> bit0 at tick 8, bit1 at tick 18, bit2 at 108,
//    bit3 at 263; DONE follows.
//  4 dump=1 asserted at tick 50 of test 3 -> pot_in=0 next ce-cycle; re-release restarts count at 0.
//  5 paddle changed 0->200 during CHARGE -> thresholds unchanged (bit0 still at tick 8).
//  6 PADDLE_SMOOTH_EN: frame1 paddle=200 (prev=0) -> pos=100, charge at tick 108;
//    frame2 paddle=200 -> pos=150, charge at tick 158.

Source files
------------

// File: rtl/paddle_pot_timer.sv
// Four-channel paddle pot charge timer: counts scanlines after the dump line is released and
// reports each channel charged once its position threshold is reached. Optional macro: PADDLE_SMOOTH_EN.
module paddle_pot_timer #(
  parameter int MIN_LINES = 8,
  parameter int STEP      = 1,
  parameter int CNT_W     = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        dump,
  input  logic        hsync,
  input  logic [31:0] paddle,
  output logic [3:0]  pot_in,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Encoding is visible on dbg_state_o: 0 = DUMP, 1 = CHARGE, 2 = DONE.
  typedef enum logic [1:0] {
    S_DUMP   = 2'd0,
    S_CHARGE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                    state_q, state_d;
  logic                      hs_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0][CNT_W-1:0]     thr_q, thr_d;
  logic [3:0][CNT_W-1:0]     thr_new;
  logic [3:0][7:0]           pos;
  logic [3:0]                pot_q, pot_d;
  logic [3:0]                cmp;
  logic                      line_tick;

  assign line_tick   = hsync & ~hs_q;
  assign pot_in      = pot_q;
  assign busy        = (state_q == S_CHARGE);
  assign dbg_state_o = state_q;

`ifdef PADDLE_SMOOTH_EN
  logic [3:0][7:0] prev_q, prev_d;
  logic [3:0][8:0] sum;

  // Rounded average of the last latched position and the new one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = {1'b0, prev_q[i]} + {1'b0, paddle[8*i +: 8]} + 9'd1;
      pos[i] = sum[i][8:1];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos[i] = paddle[8*i +: 8];
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      thr_new[i] = CNT_W'(MIN_LINES) + ({{(CNT_W-8){1'b0}}, pos[i]} * CNT_W'(STEP));
      cmp[i]     = (cnt_q >= thr_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pot_d   = pot_q;
    thr_d   = thr_q;
`ifdef PADDLE_SMOOTH_EN
    prev_d  = prev_q;
`endif
    if (dump) begin
      state_d = S_DUMP;
      cnt_d   = '0;
      pot_d   = 4'b0000;
    end else begin
      case (state_q)
        S_DUMP: begin
          // Release edge: latch thresholds; a coincident line tick is dropped.
          cnt_d   = '0;
          pot_d   = 4'b0000;
          thr_d   = thr_new;
`ifdef PADDLE_SMOOTH_EN
          prev_d  = pos;
`endif
          state_d = S_CHARGE;
        end
        S_CHARGE: begin
          pot_d = cmp;
          if (line_tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((&cmp) || (cnt_q == CNT_MAX)) begin
            state_d = S_DONE;
            pot_d   = 4'b1111;
          end
        end
        S_DONE: begin
          pot_d = 4'b1111;
        end
        default: begin
          state_d = S_DUMP;
          cnt_d   = '0;
          pot_d   = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DUMP;
      hs_q    <= 1'b0;
      cnt_q   <= '0;
      thr_q   <= '0;
      pot_q   <= 4'b0000;
`ifdef PADDLE_SMOOTH_EN
      prev_q  <= '0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      hs_q    <= hsync;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      pot_q   <= pot_d;
`ifdef PADDLE_SMOOTH_EN
      prev_q  <= prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_paddle_pot_timer.sv
// Bench for paddle_pot_timer: scanline-level reference model checked every cycle, plus directed
// literal expectations for the charge points. Honours PADDLE_SMOOTH_EN like the design.
module tb_paddle_pot_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        dump = 1'b1;
  logic        hsync = 1'b0;
  logic [31:0] paddle = '0;
  logic [3:0]  pot_in;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  paddle_pot_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .dump       (dump),
    .hsync      (hsync),
    .paddle     (paddle),
    .pot_in     (pot_in),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: lines counted since the dump release, thresholds as integers.
  logic       m_active, m_done, m_hs;
  int         m_lines;
  int         m_thr[4];
  int         m_prev[4];
  logic [3:0] m_pot;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_done = 0; m_hs = 0; m_lines = 0; m_pot = 0;
      for (int i = 0; i < 4; i++) begin m_thr[i] = 0; m_prev[i] = 0; end
    end else if (ce) begin
      logic tick;
      logic [3:0] reached;
      tick = hsync && !m_hs;
      m_hs = hsync;
      if (dump) begin
        m_active = 0; m_done = 0; m_lines = 0; m_pot = 0;
      end else if (!m_active) begin
        for (int i = 0; i < 4; i++) begin
          int p;
          p = paddle[8*i +: 8];
`ifdef PADDLE_SMOOTH_EN
          p = (m_prev[i] + p + 1) / 2;
          m_prev[i] = p;
`endif
          m_thr[i] = 8 + p;
        end
        m_active = 1; m_lines = 0; m_pot = 0;
      end else if (m_done) begin
        m_pot = 4'hF;
      end else begin
        for (int i = 0; i < 4; i++) reached[i] = (m_lines >= m_thr[i]);
        if (reached == 4'hF || m_lines == 511) begin
          m_done = 1; m_pot = 4'hF;
        end else begin
          m_pot = reached;
        end
        if (tick && m_lines < 511) m_lines++;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (pot_in !== m_pot || busy !== (m_active && !m_done)) begin
      failures++;
      $display("FAIL model pot_in=%b busy=%b required pot_in=%b busy=%b at %0t",
               pot_in, busy, m_pot, m_active && !m_done, $time);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic line();
    hsync = 1'b1; step();
    hsync = 1'b0; step(); step();
  endtask

  task automatic lines(input int n);
    for (int k = 0; k < n; k++) line();
  endtask

  task automatic release_with(input logic [31:0] p);
    dump = 1'b1; step(); step();
    paddle = p;
    dump = 1'b0; step();
  endtask

  initial begin
    #23;
    chk("reset_pot", pot_in, 4'b0000);
    chk("reset_busy", {3'b0, busy}, 4'b0000);
    chk("reset_state", {2'b0, dbg_state}, 4'd0);
    @(posedge clk); #1; reset_n = 1'b1;
    step();

`ifndef PADDLE_SMOOTH_EN
    // All paddles at 0: every channel charges one cycle after the 8th line.
    release_with(32'h0);
    chk("zero_busy", {3'b0, busy}, 4'b0001);
    lines(7);
    chk("zero_before", pot_in, 4'b0000);
    hsync = 1'b1; step();
    chk("zero_latency", pot_in, 4'b0000);
    hsync = 1'b0; step();
    chk("zero_charged", pot_in, 4'b1111);
    chk("zero_done_busy", {3'b0, busy}, 4'b0000);
    step();

    // Clock enable low: line pulses are ignored.
    release_with(32'h0);
    ce = 1'b0;
    for (int k = 0; k < 10; k++) begin hsync = 1'b1; step(); hsync = 1'b0; step(); end
    ce = 1'b1; step();
    chk("ce_hold_pot", pot_in, 4'b0000);
    chk("ce_hold_busy", {3'b0, busy}, 4'b0001);

    // Mixed positions {255,100,10,0}: charge points at lines 8, 18, 108, 263.
    release_with({8'd255, 8'd100, 8'd10, 8'd0});
    lines(8);
    chk("mix_l8", pot_in, 4'b0001);
    lines(10);
    chk("mix_l18", pot_in, 4'b0011);
    lines(32);
    // Dump at line 50 clears next cycle; re-release restarts the count.
    dump = 1'b1; step();
    chk("dump_clear", pot_in, 4'b0000);
    release_with({8'd255, 8'd100, 8'd10, 8'd0});
    lines(7);
    chk("restart_l7", pot_in, 4'b0000);
    lines(1);
    chk("restart_l8", pot_in, 4'b0001);
    lines(100);
    chk("mix_l108", pot_in, 4'b0111);
    lines(154);
    chk("mix_l262", pot_in, 4'b0111);
    lines(1);
    chk("mix_l263", pot_in, 4'b1111);
    chk("mix_done", {2'b0, dbg_state}, 4'd2);

    // Release coincident with a line pulse: that pulse is not counted.
    dump = 1'b1; step(); step();
    paddle = 32'h0; dump = 1'b0; hsync = 1'b1; step();
    hsync = 1'b0; step(); step();
    lines(7);
    chk("coincident_l7", pot_in, 4'b0000);
    lines(1);
    chk("coincident_l8", pot_in, 4'b1111);

    // Paddle change mid-charge is ignored.
    release_with(32'h0);
    lines(2);
    paddle = {4{8'd200}};
    lines(6);
    chk("paddle_ignored", pot_in, 4'b1111);

    // Asynchronous reset mid-charge.
    release_with({8'd255, 8'd100, 8'd10, 8'd0});
    lines(9);
    #2 reset_n = 1'b0; #1;
    chk("async_pot", pot_in, 4'b0000);
    chk("async_busy", {3'b0, busy}, 4'b0000);
    @(posedge clk); #1; reset_n = 1'b1; dump = 1'b1; step();
    chk("async_state", {2'b0, dbg_state}, 4'd0);
`else
    // Smoothing: 200 with prev 0 -> 100 (line 108), then 200 -> 150 (line 158).
    release_with({4{8'd200}});
    lines(107);
    chk("smooth1_l107", pot_in, 4'b0000);
    lines(1);
    chk("smooth1_l108", pot_in, 4'b1111);
    release_with({4{8'd200}});
    lines(157);
    chk("smooth2_l157", pot_in, 4'b0000);
    lines(1);
    chk("smooth2_l158", pot_in, 4'b1111);
    chk("smooth_busy", {3'b0, busy}, 4'b0000);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
